// File: rtl/sap_pkg.sv
// Shared definitions for the accumulator CPU: opcode and sequencer state encodings,
// plus the helper that tells the sequencer which execute step finishes each opcode.
package sap_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_ADD  = 4'h2,
    OP_OUT  = 4'h3,
    OP_JMP  = 4'h4,
    OP_STA  = 4'h5,
    OP_SUB  = 4'h6,
    OP_LDI  = 4'h7,
    OP_JC   = 4'h8,
    OP_JZ   = 4'h9,
    OP_HLT  = 4'hE,
    OP_NOPF = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F1,
    S_F2,
    S_E1,
    S_E2,
    S_E3,
    S_HALT
  } state_e;

  function automatic state_e last_e(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: return S_E2;
      OP_ADD, OP_SUB: return S_E3;
      default:        return S_E1;
    endcase
  endfunction

endpackage

// File: rtl/sap_if.sv
// Host-side port bundle of the CPU: program-load/start controls in, output and debug views out.
// Plain wires with no handshake; the host simply strobes start/prog_we for one cycle.
interface sap_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic              busy;
  logic [ADDR_W-1:0] pc_dbg;
  logic [DATA_W-1:0] bus_view;

  modport master (
    output start, prog_we, prog_addr, prog_data,
    input  out_data, out_valid, halted, busy, pc_dbg, bus_view
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data,
    output out_data, out_valid, halted, busy, pc_dbg, bus_view
  );
endinterface

// File: rtl/sap_tick_gen.sv
// Free-running step-rate divider: tick is high for one clk every CLK_DIV cycles.
// Zero latency from count to tick; never stalls, runs in every CPU state.
module sap_tick_gen #(
  parameter int CLK_DIV = 700000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/sap_core.sv
// Microcoded bus-based accumulator CPU: F1/F2 fetch, up to three execute steps, one step per tick.
// IDLE/HALT exit and program-load writes act on the next clk edge; no backpressure on outputs.
module sap_core import sap_pkg::*; #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int CLK_DIV = 700000
) (
  input logic  clk,
  input logic  rst_n,
  sap_if.slave host
);
  state_e            state, state_nxt;
  logic              tick, adv, parked;
  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] ir, a_reg, b_reg, out_reg, bus_dat, ram_rd;
  logic              c_flag, z_flag, out_vld;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   alu_res;
  logic              alu_c;

  logic pc_oe, ram_oe, op_oe, a_oe, alu_oe, imm_oe;
  logic mar_ld, ir_ld, a_ld, b_ld, out_ld, pc_ld, pc_inc, ram_we, flag_ld;

  logic              ram_wr;
  logic [ADDR_W-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;

  sap_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign parked  = (state == S_IDLE) || (state == S_HALT);
  assign adv     = tick && !parked;
  assign opcode  = ir[DATA_W-1:DATA_W-4];
  assign operand = ir[ADDR_W-1:0];
  assign imm     = DATA_W'(ir[DATA_W-5:0]);
  assign ram_rd  = mem[mar];

  // SUB carry is "no borrow": the extra bit is clear when A >= B.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    if (opcode == OP_SUB) begin
      alu_res = {1'b0, a_reg} - {1'b0, b_reg};
      alu_c   = ~alu_res[DATA_W];
    end else begin
      alu_res = {1'b0, a_reg} + {1'b0, b_reg};
      alu_c   = alu_res[DATA_W];
    end
  end

  // Control decode and next state; load enables take effect only on adv.
  always_comb begin
    state_nxt = state;
    pc_oe = 1'b0; ram_oe = 1'b0; op_oe = 1'b0; a_oe = 1'b0; alu_oe = 1'b0; imm_oe = 1'b0;
    mar_ld = 1'b0; ir_ld = 1'b0; a_ld = 1'b0; b_ld = 1'b0; out_ld = 1'b0;
    pc_ld = 1'b0; pc_inc = 1'b0; ram_we = 1'b0; flag_ld = 1'b0;
    case (state)
      S_IDLE, S_HALT: if (host.start) state_nxt = S_F1;
      S_F1: begin
        pc_oe  = 1'b1;
        mar_ld = 1'b1;
        if (tick) state_nxt = S_F2;
      end
      S_F2: begin
        ram_oe = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
        if (tick) state_nxt = S_E1;
      end
      S_E1, S_E2, S_E3: begin
        if (state == S_E1) begin
          case (opcode)
            OP_LDA, OP_STA, OP_ADD, OP_SUB: begin op_oe = 1'b1; mar_ld = 1'b1; end
            OP_OUT: begin a_oe = 1'b1; out_ld = 1'b1; end
            OP_JMP: begin op_oe = 1'b1; pc_ld = 1'b1; end
            OP_JC:  begin op_oe = 1'b1; pc_ld = c_flag; end
            OP_JZ:  begin op_oe = 1'b1; pc_ld = z_flag; end
            OP_LDI: begin imm_oe = 1'b1; a_ld = 1'b1; end
            default: ;
          endcase
        end else if (state == S_E2) begin
          case (opcode)
            OP_LDA:         begin ram_oe = 1'b1; a_ld = 1'b1; end
            OP_STA:         begin a_oe = 1'b1; ram_we = 1'b1; end
            OP_ADD, OP_SUB: begin ram_oe = 1'b1; b_ld = 1'b1; end
            default: ;
          endcase
        end else begin
          alu_oe  = 1'b1;
          a_ld    = 1'b1;
          flag_ld = 1'b1;
        end
        if (tick) begin
          if (state == last_e(opcode))
            state_nxt = (opcode == OP_HLT) ? S_HALT : S_F1;
          else
            state_nxt = (state == S_E1) ? S_E2 : S_E3;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_dat = '0;
    if (pc_oe)       bus_dat = DATA_W'(pc);
    else if (ram_oe) bus_dat = ram_rd;
    else if (op_oe)  bus_dat = DATA_W'(operand);
    else if (a_oe)   bus_dat = a_reg;
    else if (alu_oe) bus_dat = alu_res[DATA_W-1:0];
    else if (imm_oe) bus_dat = imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      mar     <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      out_vld <= 1'b0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
    end else begin
      state   <= state_nxt;
      out_vld <= adv && out_ld;
      if (parked && host.start) pc <= '0;
      if (adv) begin
        if (mar_ld) mar <= bus_dat[ADDR_W-1:0];
        if (ir_ld)  ir <= bus_dat;
        if (pc_inc) pc <= pc + 1'b1;
        else if (pc_ld) pc <= bus_dat[ADDR_W-1:0];
        if (a_ld)   a_reg <= bus_dat;
        if (b_ld)   b_reg <= bus_dat;
        if (out_ld) out_reg <= bus_dat;
        if (flag_ld) begin
          c_flag <= alu_c;
          z_flag <= (alu_res[DATA_W-1:0] == '0);
        end
      end
    end
  end

  // The load port owns the single write port whenever the sequencer is parked.
  assign ram_wr = (adv && ram_we) || (parked && host.prog_we);
  assign ram_wa = parked ? host.prog_addr : mar;
  assign ram_wd = parked ? host.prog_data : bus_dat;

  always_ff @(posedge clk) begin
    if (ram_wr) mem[ram_wa] <= ram_wd;
  end

  assign host.out_data  = out_reg;
  assign host.out_valid = out_vld;
  assign host.halted    = (state == S_HALT);
  assign host.busy      = !parked;
  assign host.pc_dbg    = pc;
  assign host.bus_view  = b_reg;
endmodule

// File: tb/tb_sap_core.sv
// Directed and random programs checked against an instruction-level model of the CPU.
module tb_sap_core;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sap_if #(.DATA_W(DW), .ADDR_W(AW)) host ();

  sap_core #(.DATA_W(DW), .ADDR_W(AW), .CLK_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host)
  );

  int nvec = 0;
  int nfail = 0;

  // Instruction-level reference state
  logic [7:0] m_ram [16];
  logic [7:0] m_a, m_b, m_out;
  logic       m_c, m_z;
  logic [3:0] m_pc;
  int         exp_tk[$];
  logic [7:0] exp_val[$];
  int         exp_halt;

  // Observation state
  int         ph, tk, cyc, halt_tk, probe_pc;
  bit         seen_halt, probed;
  logic [7:0] got_val[$];
  int         got_tk[$];
  int         got_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs the program from PC=0 for up to budget ticks, costing each instruction by its step count.
  task automatic model_run(input int budget);
    int t, op, arg;
    bit done;
    logic [8:0] s;
    t = 0; done = 0; exp_halt = -1; m_pc = 4'd0;
    exp_tk.delete(); exp_val.delete();
    while (!done && t < budget) begin
      op  = int'(m_ram[m_pc][7:4]);
      arg = int'(m_ram[m_pc][3:0]);
      m_pc = m_pc + 4'd1;
      case (op)
        1: begin m_a = m_ram[arg]; t += 4; end
        2: begin
          m_b = m_ram[arg];
          s = {1'b0, m_a} + {1'b0, m_b};
          m_c = s[8]; m_a = s[7:0]; m_z = (m_a == 8'd0); t += 5;
        end
        3: begin
          t += 3; m_out = m_a;
          if (t <= budget) begin exp_val.push_back(m_a); exp_tk.push_back(t); end
        end
        4: begin m_pc = 4'(arg); t += 3; end
        5: begin m_ram[arg] = m_a; t += 4; end
        6: begin
          m_b = m_ram[arg];
          m_c = (m_a >= m_b); m_a = m_a - m_b; m_z = (m_a == 8'd0); t += 5;
        end
        7: begin m_a = 8'(arg); t += 3; end
        8: begin if (m_c) m_pc = 4'(arg); t += 3; end
        9: begin if (m_z) m_pc = 4'(arg); t += 3; end
        14: begin t += 3; done = 1; if (t <= budget) exp_halt = t; end
        default: t += 3;
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (!rst_n) ph = 0;
    else begin
      ph = (ph + 1) % DIV;
      if (ph == 0) tk++;
    end
    if (host.out_valid) begin
      got_val.push_back(host.out_data); got_tk.push_back(tk); got_cyc.push_back(cyc);
    end
    if (host.halted && !seen_halt) begin seen_halt = 1; halt_tk = tk; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst:out_data", host.out_data, 0);
    chk("rst:out_valid", host.out_valid, 0);
    chk("rst:halted", host.halted, 0);
    chk("rst:busy", host.busy, 0);
    chk("rst:pc_dbg", host.pc_dbg, 0);
    chk("rst:bus_view", host.bus_view, 0);
    step(); step();
    rst_n = 1'b1;
    m_a = 8'd0; m_b = 8'd0; m_c = 1'b0; m_z = 1'b0; m_out = 8'd0;
  endtask

  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    host.prog_we = 1'b1; host.prog_addr = addr; host.prog_data = data;
    m_ram[addr] = data;
    step();
    host.prog_we = 1'b0;
  endtask

  task automatic do_start(input bit we, input logic [3:0] wa, input logic [7:0] wd);
    host.start = 1'b1;
    host.prog_we = we; host.prog_addr = wa; host.prog_data = wd;
    step();
    host.start = 1'b0; host.prog_we = 1'b0;
    tk = 0; cyc = 0; seen_halt = 0; probed = 0; probe_pc = -1;
    got_val.delete(); got_tk.delete(); got_cyc.delete();
  endtask

  task automatic run_check(input string tag, input int budget, input bit swe,
                           input logic [3:0] wa, input logic [7:0] wd,
                           input bit busy_we, input int probe_tk);
    int lim;
    if (swe) m_ram[wa] = wd;
    model_run(budget);
    do_start(swe, wa, wd);
    if (busy_we) begin
      chk({tag, ":busy_at_we"}, host.busy, 1);
      host.prog_we = 1'b1; host.prog_addr = wa; host.prog_data = ~wd;
      step();
      host.prog_we = 1'b0;
    end
    lim = (budget + 2) * DIV + 8;
    for (int i = 0; i < lim && !seen_halt && tk < budget; i++) begin
      step();
      if (!probed && tk == probe_tk) begin probed = 1; probe_pc = int'(host.pc_dbg); end
    end
    chk({tag, ":halted"}, seen_halt, exp_halt >= 0);
    if (exp_halt >= 0) chk({tag, ":halt_tick"}, halt_tk, exp_halt);
    chk({tag, ":n_out"}, got_val.size(), exp_val.size());
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      chk($sformatf("%s:out%0d", tag, i), got_val[i], exp_val[i]);
      chk($sformatf("%s:out_tick%0d", tag, i), got_tk[i], exp_tk[i]);
    end
    if (exp_halt >= 0 && seen_halt) begin
      chk({tag, ":pc"}, host.pc_dbg, m_pc);
      chk({tag, ":bus_view"}, host.bus_view, m_b);
      chk({tag, ":out_data"}, host.out_data, m_out);
      chk({tag, ":busy"}, host.busy, 0);
    end
  endtask

  initial begin
    host.start = 1'b0; host.prog_we = 1'b0; host.prog_addr = '0; host.prog_data = '0;
    ph = 0; tk = 0; cyc = 0;
    for (int i = 0; i < 16; i++) m_ram[i] = 8'd0;
    do_reset();

    // LDI 0xF, ADD 0xFF -> 0x0E with carry, OUT, HLT
    load(4'd0, 8'h7F); load(4'd1, 8'h24); load(4'd2, 8'h30); load(4'd3, 8'hE0); load(4'd4, 8'hFF);
    run_check("ldi_add", 60, 0, 4'd0, 8'd0, 0, -1);
    chk("ldi_add:out_hand", host.out_data, 8'h0E);
    chk("ldi_add:ticks_hand", halt_tk, 14);

    // 5-5 = 0 sets Z, JZ lands on OUT at 0xA
    load(4'd0, 8'h75); load(4'd1, 8'h6F); load(4'd2, 8'h9A); load(4'd3, 8'h30);
    load(4'd4, 8'hE0); load(4'd10, 8'h30); load(4'd11, 8'hE0); load(4'd15, 8'h05);
    run_check("sub_jz", 60, 0, 4'd0, 8'd0, 0, 11);
    chk("sub_jz:pc_after_jz", probe_pc, 10);
    chk("sub_jz:pc_hand", host.pc_dbg, 12);

    // 1+1 clears C, JC falls through
    load(4'd0, 8'h71); load(4'd1, 8'h2F); load(4'd2, 8'h80); load(4'd3, 8'h30);
    load(4'd4, 8'hE0); load(4'd15, 8'h01);
    run_check("jc_not", 60, 0, 4'd0, 8'd0, 0, -1);
    chk("jc_not:out_hand", host.out_data, 8'h02);

    // Load port: ignored while busy, honoured in HALT and alongside start
    load(4'd0, 8'h1F); load(4'd1, 8'h30); load(4'd2, 8'hE0); load(4'd15, 8'h55);
    run_check("ld_busy", 60, 0, 4'd15, 8'h55, 1, -1);
    chk("ld_busy:out_hand", host.out_data, 8'h55);
    load(4'd15, 8'hAA);
    run_check("ld_halt", 60, 0, 4'd0, 8'd0, 0, -1);
    chk("ld_halt:out_hand", host.out_data, 8'hAA);
    run_check("ld_start", 60, 1, 4'd15, 8'h77, 0, -1);
    chk("ld_start:out_hand", host.out_data, 8'h77);

    // Reset during E2 of ADD, then rerun from IDLE
    load(4'd0, 8'h73); load(4'd1, 8'h2F); load(4'd2, 8'h30); load(4'd3, 8'hE0); load(4'd15, 8'h21);
    run_check("rst_pre", 60, 0, 4'd0, 8'd0, 0, -1);
    do_start(0, 4'd0, 8'd0);
    for (int i = 0; i < 64 && tk < 6; i++) step();
    chk("rst_mid:busy", host.busy, 1);
    chk("rst_mid:pc", host.pc_dbg, 2);
    do_reset();
    run_check("rst_rerun", 60, 0, 4'd0, 8'd0, 0, -1);
    chk("rst_rerun:out_hand", host.out_data, 8'h24);

    // Doubling loop: 1,2,4,...,0x80,0
    load(4'd0, 8'h1E); load(4'd1, 8'h5F); load(4'd2, 8'h1F); load(4'd3, 8'h30);
    load(4'd4, 8'h2F); load(4'd5, 8'h5F); load(4'd6, 8'h42); load(4'd14, 8'h01);
    run_check("count", 200, 0, 4'd0, 8'd0, 0, -1);
    chk("count:first", got_val[0], 8'h01);
    chk("count:peak", got_val[7], 8'h80);
    chk("count:wrap", got_val[8], 8'h00);
    chk("count:spacing_clk", got_cyc[1] - got_cyc[0], 19 * DIV);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 16; i++) load(4'(i), 8'($urandom));
      run_check($sformatf("rand%0d", r), 150, 0, 4'd0, 8'd0, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
